// File: rtl/fft_pkg.sv
// Shared constants and state encodings for the FFT result collector.
// Word layout is {real[31:16], imag[15:0]}; the collector never splits it.
package fft_pkg;

    localparam int FRAME_LEN = 64;
    localparam int DW        = 32;

    typedef enum logic [1:0] {
        BANK_FREE,
        BANK_FILL,
        BANK_READY
    } bank_state_e;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_WRITE,
        WR_DROP
    } wr_state_e;

endpackage

// File: rtl/collector_bank_ram.sv
// Dual-bank frame store: one write port, one registered read port.
// The bank number is the address MSB; read data holds when re_i is low.
module collector_bank_ram #(
    parameter int DW = 32,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_result_collector.sv
// Ping-pong collector for FFT output frames: a writer fills free banks,
// the host reads the oldest ready bank and releases it when done.
module fft_result_collector #(
    parameter int FRAME_LEN = fft_pkg::FRAME_LEN,
    parameter int DW        = fft_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] fft_data,
    input  logic          fft_valid,
    input  logic          rd_en,
    input  logic [5:0]    rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          frame_ready,
    input  logic          frame_release,
    output logic          overflow,
    input  logic          clr_ovf,
    output logic [7:0]    drop_cnt
);

    import fft_pkg::*;

    localparam int            AW       = $clog2(FRAME_LEN);
    localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);

    bank_state_e   bank_state_q [2];
    wr_state_e     wr_state_q;
    logic          wr_bank_q;
    logic [AW-1:0] wr_idx_q;
    logic          rd_bank_q;
    logic          rd_valid_q;
    logic          overflow_q;
    logic [7:0]    drop_cnt_q;

    logic          ready_now;
    logic          release_now;
    logic          rd_fire;
    logic          start_bank;
    logic          start_ok;
    logic          complete;
    logic          ram_we;
    logic [AW:0]   ram_waddr;

    // Free-bank decisions use registered state only, so a bank released
    // this cycle cannot take a frame that starts in the same cycle.
    assign ready_now   = (bank_state_q[rd_bank_q] == BANK_READY);
    assign release_now = frame_release && ready_now;
    assign rd_fire     = rd_en && ready_now;
    assign start_bank  = (bank_state_q[0] != BANK_FREE);
    assign start_ok    = (wr_state_q == WR_IDLE) && fft_valid &&
                         ((bank_state_q[0] == BANK_FREE) || (bank_state_q[1] == BANK_FREE));
    assign complete    = (wr_state_q == WR_WRITE) && fft_valid && (wr_idx_q == LAST_IDX);

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = {wr_bank_q, wr_idx_q};
        if (start_ok) begin
            ram_we    = 1'b1;
            ram_waddr = {start_bank, {AW{1'b0}}};
        end else if ((wr_state_q == WR_WRITE) && fft_valid) begin
            ram_we = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_state_q[0] <= BANK_FREE;
            bank_state_q[1] <= BANK_FREE;
            wr_state_q      <= WR_IDLE;
            wr_bank_q       <= 1'b0;
            wr_idx_q        <= '0;
            rd_bank_q       <= 1'b0;
            rd_valid_q      <= 1'b0;
            overflow_q      <= 1'b0;
            drop_cnt_q      <= '0;
        end else begin
            rd_valid_q <= rd_fire;

            for (int b = 0; b < 2; b++) begin
                if (release_now && (rd_bank_q == 1'(b))) begin
                    bank_state_q[b] <= BANK_FREE;
                end else if (complete && (wr_bank_q == 1'(b))) begin
                    bank_state_q[b] <= BANK_READY;
                end else if (start_ok && (start_bank == 1'(b))) begin
                    bank_state_q[b] <= BANK_FILL;
                end
            end

            // A completing bank becomes the read target only if the other
            // bank is not already holding an older ready frame.
            if (release_now) begin
                rd_bank_q <= ~rd_bank_q;
            end else if (complete && (bank_state_q[~wr_bank_q] != BANK_READY)) begin
                rd_bank_q <= wr_bank_q;
            end

            if (clr_ovf) begin
                overflow_q <= 1'b0;
            end

            case (wr_state_q)
                WR_IDLE: begin
                    if (fft_valid) begin
                        wr_idx_q <= AW'(1);
                        if (start_ok) begin
                            wr_bank_q  <= start_bank;
                            wr_state_q <= WR_WRITE;
                        end else begin
                            wr_state_q <= WR_DROP;
                            overflow_q <= 1'b1;
                            if (drop_cnt_q != 8'hFF) begin
                                drop_cnt_q <= drop_cnt_q + 8'd1;
                            end
                        end
                    end
                end
                WR_WRITE, WR_DROP: begin
                    if (fft_valid) begin
                        if (wr_idx_q == LAST_IDX) begin
                            wr_idx_q   <= '0;
                            wr_state_q <= WR_IDLE;
                        end else begin
                            wr_idx_q <= wr_idx_q + 1'b1;
                        end
                    end
                end
                default: wr_state_q <= WR_IDLE;
            endcase
        end
    end

    collector_bank_ram #(
        .DW (DW),
        .AW (AW + 1)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (fft_data),
        .re_i    (rd_fire),
        .raddr_i ({rd_bank_q, rd_addr[AW-1:0]}),
        .rdata_o (rd_data)
    );

    assign rd_valid    = rd_valid_q;
    assign frame_ready = ready_now;
    assign overflow    = overflow_q;
    assign drop_cnt    = drop_cnt_q;

endmodule
